// File: rtl/spike_bin_fifo.sv
// rtl/spike_bin_fifo.sv - multi-channel spike binning with header-plus-data record FIFO
//
// Counts rising edges on NCH spike lines between bin_tick strobes. An accepted
// tick snapshots every channel count and serialises one record into a 16-bit
// word FIFO: one header word {4'hA, bin_index} and then one word per channel.
// The host side drains the FIFO one word per cycle.
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-low
//   enable      counting and tick acceptance on
//   per_bin     clear counters at each accepted tick (else cumulative)
//   spike       NCH level spike inputs
//   bin_tick    single-cycle bin-end strobe
//   rd_en       read request, one word per cycle
//   rd_data     registered read word (1-cycle latency)
//   rd_valid    rd_data holds a freshly read word
//   empty/full  FIFO status, registered
//   level       FIFO occupancy 0..DEPTH, registered
//   drop_count  records dropped for lack of space, saturating
//   miss_count  ticks ignored while the serialiser was busy, saturating
//   busy        serialiser is writing a record

module spike_bin_fifo #(
    parameter int NCH   = 8,
    parameter int CW    = 16,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              per_bin,
    input  logic [NCH-1:0]    spike,
    input  logic              bin_tick,
    input  logic              rd_en,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       level,
    output logic [15:0]       drop_count,
    output logic [15:0]       miss_count,
    output logic              busy
);

    localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] REC_W   = (AW+1)'(NCH + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state;
    logic [NCH-1:0]  spike_prev;
    logic [NCH-1:0]  spike_edge;
    logic [CW-1:0]   count     [NCH];
    logic [CW-1:0]   count_upd [NCH];
    logic [CW-1:0]   shadow    [NCH];
    logic [11:0]     bin_index;
    logic [15:0]     hdr_word;
    logic [KW-1:0]   k;

    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level_next;

    logic            tick_en;
    logic            tick_acc;
    logic            tick_miss;
    logic            has_space;
    logic            wr_en;
    logic            rd_fire;
    logic [15:0]     wr_data;

    // Edge detection: spike_prev tracks the inputs even while disabled, so a
    // line that rose during a disabled stretch is not counted on re-enable.
    assign spike_edge = enable ? (spike & ~spike_prev) : '0;

    assign tick_en   = enable & bin_tick;
    assign tick_acc  = tick_en & (state == IDLE);
    assign tick_miss = tick_en & (state != IDLE);

    // A whole record must fit before the header is written, so the write side
    // never has to check full.
    assign has_space = (DEPTH_W - level) >= REC_W;

    assign wr_en   = (state == HDR) || (state == DATA);
    assign wr_data = (state == HDR) ? hdr_word : 16'(shadow[k]);
    assign rd_fire = rd_en & ~empty;

    assign level_next = level + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_fire};

    // Saturating per-channel increment, including an edge that lands in the
    // tick cycle (it belongs to the closing bin).
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            count_upd[i] = count[i];
            if (spike_edge[i] && (count[i] != {CW{1'b1}})) begin
                count_upd[i] = count[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            spike_prev <= '0;
            for (int i = 0; i < NCH; i++) begin
                count[i]  <= '0;
                shadow[i] <= '0;
            end
        end else begin
            spike_prev <= spike;
            for (int i = 0; i < NCH; i++) begin
                if (tick_acc) begin
                    shadow[i] <= count_upd[i];
                    count[i]  <= per_bin ? '0 : count_upd[i];
                end else begin
                    count[i]  <= count_upd[i];
                end
            end
        end
    end

    // Record serialiser. The header is latched at acceptance because
    // bin_index advances in the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            k          <= '0;
            hdr_word   <= '0;
            bin_index  <= '0;
            drop_count <= '0;
            miss_count <= '0;
        end else begin
            if (tick_en) begin
                bin_index <= bin_index + 12'd1;
            end
            if (tick_miss && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (tick_acc) begin
                        hdr_word <= {4'hA, bin_index};
                        if (has_space) begin
                            state <= HDR;
                            busy  <= 1'b1;
                        end else if (drop_count != 16'hFFFF) begin
                            drop_count <= drop_count + 16'd1;
                        end
                    end
                end
                HDR: begin
                    state <= DATA;
                    k     <= '0;
                end
                DATA: begin
                    if (k == K_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; contents need no reset because the pointers define
    // which words are live.
    always_ff @(posedge clk) begin
        if (wr_en && reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr   <= rd_ptr + AW'(1);
                rd_data  <= mem[rd_ptr];
                rd_valid <= 1'b1;
            end else begin
                rd_valid <= 1'b0;
            end
            level <= level_next;
            empty <= (level_next == '0);
            full  <= (level_next == DEPTH_W);
        end
    end

endmodule
